ysyx_23060208_pcgen: RTL

YSYX_23060208_PCGEN -- requirements
Module: ysyx_23060208_pcgen

---
 rtl/ysyx_23060208_pkg.sv | 13 +
 rtl/ysyx_23060208_pcgen.sv | 85 ++++++++
 2 files changed

// File: rtl/ysyx_23060208_pkg.sv
// Shared types and constants for the ysyx_23060208 front end.
// Holds the PC generator FSM encoding and the default boot address.
package ysyx_23060208_pkg;

   typedef enum logic [1:0] {
      StBoot = 2'd0,
      StRun  = 2'd1,
      StHalt = 2'd2
   } pcgen_state_e;

   localparam logic [31:0] DefaultResetVector = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060208_pcgen.sv
// PC generator: boots at RESET_VECTOR, steps sequentially on fetch handshake,
// and takes trap/branch redirects (trap wins) with an epoch tag that flips per redirect.
module ysyx_23060208_pcgen
   import ysyx_23060208_pkg::*;
#(
   parameter int unsigned            DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0]  RESET_VECTOR = DATA_WIDTH'(DefaultResetVector),
   parameter int unsigned            STEP         = 4,
   parameter int unsigned            ALIGN_BITS   = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_pc,
   output logic                  out_epoch,
   input  logic                  trap_valid,
   input  logic [DATA_WIDTH-1:0] trap_pc,
   input  logic                  br_valid,
   input  logic [DATA_WIDTH-1:0] br_pc,
   input  logic                  halt_req
);

   localparam logic [DATA_WIDTH-1:0] AlignMask =
      ~((DATA_WIDTH'(1) << ALIGN_BITS) - DATA_WIDTH'(1));
   localparam logic [DATA_WIDTH-1:0] StepInc = DATA_WIDTH'(STEP);

   pcgen_state_e          state;
   logic                  redirect;
   logic                  fire;
   logic [DATA_WIDTH-1:0] target;

   assign redirect = trap_valid | br_valid;
   assign fire     = out_valid & out_ready;
   assign target   = (trap_valid ? trap_pc : br_pc) & AlignMask;

   // All outputs are registered so nothing on the inputs reaches them combinationally.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= StBoot;
         out_valid <= 1'b0;
         out_pc    <= RESET_VECTOR;
         out_epoch <= 1'b0;
      end else begin
         unique case (state)
            StBoot: begin
               state     <= StRun;
               out_valid <= 1'b1;
               if (redirect) begin
                  out_pc    <= target;
                  out_epoch <= ~out_epoch;
               end
            end
            StRun: begin
               if (redirect) begin
                  // A same-cycle fire is still delivered; the target replaces the increment.
                  out_pc    <= target;
                  out_epoch <= ~out_epoch;
               end else begin
                  if (fire) begin
                     out_pc <= out_pc + StepInc;
                  end
                  if (halt_req) begin
                     state     <= StHalt;
                     out_valid <= 1'b0;
                  end
               end
            end
            StHalt: begin
               if (redirect) begin
                  state     <= StRun;
                  out_valid <= 1'b1;
                  out_pc    <= target;
                  out_epoch <= ~out_epoch;
               end
            end
            default: begin
               state     <= StBoot;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
